// File: rtl/ex_muldiv_if.sv
// EX-stage mul/div handshake bundle: start/op/operands, flush, MTHI/MTLO
// writes, and the stall/done/HI/LO results.
interface ex_muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] mt_data;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush, mthi, mtlo, mt_data,
        input  stall, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush, mthi, mtlo, mt_data,
        output stall, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
// One shift-add (multiply) or restoring-divide step per clock on operand
// magnitudes, then a sign-fix cycle that writes HI/LO and pulses done.
// Optional build macro MULDIV_EARLY_OUT_EN: multiply leaves the iteration
// loop once the remaining multiplier bits are all zero.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    ex_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_SIGN, S_DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               rs_neg;
    logic               rt_neg;
    logic [2*WIDTH-1:0] acc;     // product, or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand;   // shifted multiplicand; low half keeps |rs| for divide
    logic [WIDTH-1:0]   bop;     // multiplier (shifts right) or divisor (static)
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic               rs_neg_in;
    logic               rt_neg_in;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [2*WIDTH-1:0] acc_mul;
    logic [WIDTH:0]     div_tmp;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_div;
    logic               last;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Operand magnitudes, one iteration step of each algorithm, and sign fix-up
    always_comb begin
        rs_neg_in = ~bus.op[0] & bus.rs_val[WIDTH-1];
        rt_neg_in = ~bus.op[0] & bus.rt_val[WIDTH-1];
        rs_mag    = rs_neg_in ? -bus.rs_val : bus.rs_val;
        rt_mag    = rt_neg_in ? -bus.rt_val : bus.rt_val;

        acc_mul   = bop[0] ? acc + mcand : acc;

        // Shift the next dividend bit into the remainder, subtract if it fits
        div_tmp   = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = div_tmp >= {1'b0, bop};
        div_rem   = div_ge ? (div_tmp[WIDTH-1:0] - bop) : div_tmp[WIDTH-1:0];
        acc_div   = {div_rem, acc[WIDTH-2:0], div_ge};

        last      = (cnt == CW'(1));
`ifdef MULDIV_EARLY_OUT_EN
        // The multiplicand is kept left-shifted in place, so acc is already aligned
        if (!is_div && bop[WIDTH-1:1] == '0)
            last = 1'b1;
`else
        // Fixed WIDTH iterations for every op
`endif

        prod      = (rs_neg ^ rt_neg) ? -acc : acc;
        quo       = (rs_neg ^ rt_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem       = rs_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        // Divide by zero: all-ones quotient, raw dividend as remainder
        if (bop == '0) begin
            quo = '1;
            rem = rs_neg ? -mcand[WIDTH-1:0] : mcand[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            rs_neg <= 1'b0;
            rt_neg <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            bop    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.mthi) hi_r <= bus.mt_data;
                    if (bus.mtlo) lo_r <= bus.mt_data;
                    // A squash in IDLE kills the op entering EX; DONE ignores flush
                    if (bus.start && !(state == S_IDLE && bus.flush)) begin
                        is_div <= bus.op[1];
                        rs_neg <= rs_neg_in;
                        rt_neg <= rt_neg_in;
                        cnt    <= CW'(WIDTH);
                        bop    <= rt_mag;
                        mcand  <= {{WIDTH{1'b0}}, rs_mag};
                        acc    <= bus.op[1] ? {{WIDTH{1'b0}}, rs_mag} : '0;
                        state  <= S_BUSY;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (is_div) begin
                            acc <= acc_div;
                        end else begin
                            acc   <= acc_mul;
                            mcand <= mcand << 1;
                            bop   <= bop >> 1;
                        end
                        if (last) state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            hi_r <= rem;
                            lo_r <= quo;
                        end else begin
                            {hi_r, lo_r} <= prod;
                        end
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall = rst_n & ((state == S_IDLE & bus.start) |
                                 state == S_BUSY | state == S_SIGN);
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: the driver pushes the expected HI/LO
// and done cycle for each accepted op, a negedge monitor pops on done.
module tb_ex_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(W)) bus();
    ex_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        string        name;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic int bitlen(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    // Reference: plain 64-bit arithmetic plus the documented special cases
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output int lat);
        longint sa, sbv, p;
        logic [63:0] u;
        logic [W-1:0] bm;
        lat = W + 1;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        hi = '0; lo = '0;
        case (op)
            2'd0: begin
                p = sa * sbv;
                {hi, lo} = p;
                bm = b[W-1] ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
                lat = ((bitlen(bm) < 1) ? 1 : bitlen(bm)) + 1;
`endif
            end
            2'd1: begin
                u = {32'b0, a} * {32'b0, b};
                {hi, lo} = u;
                bm = b;
`ifdef MULDIV_EARLY_OUT_EN
                lat = ((bitlen(bm) < 1) ? 1 : bitlen(bm)) + 1;
`endif
            end
            2'd2: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = W'(sa / sbv); hi = W'(sa % sbv); end
            end
            default: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start for the current cycle; caller advances and drops start
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string nm, input bit push);
        exp_t e;
        int lat;
        model(op, a, b, e.hi, e.lo, lat);
        e.cyc  = cyc + 1 + lat;
        e.name = nm;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        if (push) exp_q.push_back(e);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string nm);
        issue(op, a, b, nm, 1'b1);
        step();
        bus.start = 1'b0;
        wait_idle();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        chk("done_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding op
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
                chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0;
        bus.flush = 0; bus.mthi = 0; bus.mtlo = 0; bus.mt_data = 0;
        repeat (3) step();
        bus.start = 1'b1;
        #1;
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        bus.start = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // MULTU max*max with stall trace across the whole op
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b1);
        #1 chk("stall_start", 64'(bus.stall), 64'd1);
        step();
        bus.start = 1'b0;
        for (int k = 0; k <= W; k++) begin
            chk("stall_busy", 64'(bus.stall), 64'd1);
            step();
        end
        chk("stall_done", 64'(bus.stall), 64'd0);
        wait_idle();

        run_op(2'd0, -32'sd7, 32'd3, "mult_neg");
        run_op(2'd2, -32'sd7, 32'd2, "div_neg");
        run_op(2'd3, 32'd7, 32'd0, "divu_zero");
        run_op(2'd2, -32'sd7, 32'd0, "div_zero");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'd1, 32'd3, 32'd5, "multu_small");
        run_op(2'd0, 32'd12345, 32'd0, "mult_zero");
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

        // Flush mid-divide: HI/LO untouched, no done, mid-op start ignored
        bus.mthi = 1; bus.mtlo = 1; bus.mt_data = 32'h55;
        step();
        bus.mthi = 0; bus.mtlo = 0;
        chk("mt_both_hi", 64'(bus.hi), 64'h55);
        chk("mt_both_lo", 64'(bus.lo), 64'h55);
        issue(2'd3, 32'd1000, 32'd7, "divu_flushed", 1'b0);
        step();
        bus.start = 1'b0;
        repeat (5) step();
        issue(2'd1, 32'd9, 32'd9, "ignored_start", 1'b0);
        step();
        bus.start = 1'b0;
        repeat (4) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_stall", 64'(bus.stall), 64'd0);
        chk("flush_hi", 64'(bus.hi), 64'h55);
        chk("flush_lo", 64'(bus.lo), 64'h55);
        repeat (40) step();
        chk("flush_hi_late", 64'(bus.hi), 64'h55);
        chk("flush_lo_late", 64'(bus.lo), 64'h55);

        // MTHI while busy is dropped; MTHI in IDLE lands next cycle
        issue(2'd1, 32'd3, 32'd5, "multu_mt", 1'b1);
        step();
        bus.start = 1'b0;
        step();
        bus.mthi = 1'b1; bus.mt_data = 32'h1234;
        step();
        bus.mthi = 1'b0;
        chk("mthi_busy", 64'(bus.hi), 64'h55);
        wait_idle();
        bus.mthi = 1'b1; bus.mt_data = 32'h1234;
        step();
        bus.mthi = 1'b0;
        chk("mthi_idle", 64'(bus.hi), 64'h1234);
        chk("mthi_idle_lo", 64'(bus.lo), 64'd15);

        // MTLO alongside start: lands now, result overwrites later
        bus.mtlo = 1'b1; bus.mt_data = 32'hABCD;
        issue(2'd1, 32'd2, 32'd3, "multu_mtlo", 1'b1);
        step();
        bus.start = 1'b0; bus.mtlo = 1'b0;
        chk("mtlo_with_start", 64'(bus.lo), 64'hABCD);
        wait_idle();

        // Async reset mid-multiply
        issue(2'd0, -32'sd5, 32'd9, "mult_rst", 1'b0);
        step();
        bus.start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", 64'(bus.hi), 64'd0);
        chk("midrst_lo", 64'(bus.lo), 64'd0);
        chk("midrst_stall", 64'(bus.stall), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Randomized ops with corner-value bias
        for (int n = 0; n < 40; n++) begin
            logic [1:0] rop;
            logic [W-1:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            run_op(rop, ra, rb, $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
